// File: rtl/home_action_sched_if.sv
// Home-scene action bus: key requests, durations and abort in; active/done/leave status out.
// The scheduler takes the slave side; the key/timebase front end takes the master side.
interface home_action_sched_if #(
  parameter int N_ACT = 4,
  parameter int DUR_W = 8
);
  logic                     tick;
  logic [N_ACT-1:0]         act_req;
  logic                     leave_req;
  logic [N_ACT*DUR_W-1:0]   act_dur;
  logic                     abort;
  logic [N_ACT-1:0]         act_active;
  logic [N_ACT-1:0]         act_done;
  logic                     leave_home;
  logic                     busy;
  logic [1:0]               state;

  modport master (
    output tick, act_req, leave_req, act_dur, abort,
    input  act_active, act_done, leave_home, busy, state
  );

  modport slave (
    input  tick, act_req, leave_req, act_dur, abort,
    output act_active, act_done, leave_home, busy, state
  );
endinterface

// File: rtl/home_action_sched.sv
// home_action_sched: arbitrates timed pet actions and leave-home, with post-action cooldown.
// Optional macro ACT_QUEUE_EN adds a one-entry pending action launched back-to-back.
module home_action_sched #(
  parameter int N_ACT      = 4,
  parameter int DUR_W      = 8,
  parameter int COOL_TICKS = 4
) (
  input logic                clk,
  input logic                resetn,
  home_action_sched_if.slave bus
);

  localparam int IDX_W  = (N_ACT > 1) ? $clog2(N_ACT) : 1;
  localparam int CCNT_W = (COOL_TICKS > 0) ? $clog2(COOL_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    COOL  = 2'd2,
    LEAVE = 2'd3
  } state_t;

  state_t             st;
  logic [N_ACT:0]     hist;
  logic [DUR_W-1:0]   cnt;
  logic [CCNT_W-1:0]  ccnt;
  logic [IDX_W-1:0]   sel;
  logic [N_ACT-1:0]   act_active_r;
  logic [N_ACT-1:0]   act_done_r;
  logic               leave_home_r;
  logic               busy_r;

  logic [N_ACT:0]     rise;
  logic [N_ACT-1:0]   act_rise;
  logic               leave_rise;
  logic               any_rise;
  logic [IDX_W-1:0]   first_i;
  logic [DUR_W-1:0]   first_dur;
  logic               run_end;
  logic               cool_end;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_ACT-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_ACT - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // A zero duration still runs for one tick so every action produces a done pulse.
  function automatic logic [DUR_W-1:0] dur_of(input logic [N_ACT*DUR_W-1:0] durs,
                                              input logic [IDX_W-1:0]       idx);
    logic [DUR_W-1:0] d;
    d = durs[int'(idx)*DUR_W +: DUR_W];
    return (d == '0) ? DUR_W'(1) : d;
  endfunction

  function automatic logic [N_ACT-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [N_ACT-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  always_comb begin
    rise       = {bus.leave_req, bus.act_req} & ~hist;
    act_rise   = rise[N_ACT-1:0];
    leave_rise = rise[N_ACT];
    any_rise   = |act_rise;
    first_i    = lowest_set(act_rise);
    first_dur  = dur_of(bus.act_dur, first_i);
    run_end    = bus.tick && (cnt == DUR_W'(1));
    cool_end   = bus.tick && (ccnt <= CCNT_W'(1));
  end

`ifdef ACT_QUEUE_EN
  logic               pend_v;
  logic [IDX_W-1:0]   pend_i;
  logic               chain_v;
  logic [IDX_W-1:0]   chain_i;
  logic [DUR_W-1:0]   chain_dur;

  // A rise arriving on the very clk a slot frees up is launched as if it had been queued.
  always_comb begin
    chain_v   = pend_v | any_rise;
    chain_i   = pend_v ? pend_i : first_i;
    chain_dur = dur_of(bus.act_dur, chain_i);
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      st           <= IDLE;
      hist         <= '1;
      cnt          <= '0;
      ccnt         <= '0;
      sel          <= '0;
      act_active_r <= '0;
      act_done_r   <= '0;
      leave_home_r <= 1'b0;
      busy_r       <= 1'b0;
`ifdef ACT_QUEUE_EN
      pend_v       <= 1'b0;
      pend_i       <= '0;
`endif
    end else begin
      hist         <= {bus.leave_req, bus.act_req};
      act_done_r   <= '0;
      leave_home_r <= 1'b0;
      unique case (st)
        IDLE: begin
          if (leave_rise) begin
            st           <= LEAVE;
            leave_home_r <= 1'b1;
            busy_r       <= 1'b1;
          end else if (any_rise) begin
            st           <= RUN;
            sel          <= first_i;
            cnt          <= first_dur;
            act_active_r <= onehot(first_i);
            busy_r       <= 1'b1;
          end
        end
        RUN: begin
          if (bus.abort) begin
            st           <= IDLE;
            act_active_r <= '0;
            busy_r       <= 1'b0;
`ifdef ACT_QUEUE_EN
            pend_v       <= 1'b0;
`endif
          end else if (run_end) begin
            act_done_r   <= onehot(sel);
            act_active_r <= '0;
            if (COOL_TICKS != 0) begin
              st   <= COOL;
              ccnt <= CCNT_W'(COOL_TICKS);
`ifdef ACT_QUEUE_EN
            end else if (chain_v) begin
              st           <= RUN;
              sel          <= chain_i;
              cnt          <= chain_dur;
              act_active_r <= onehot(chain_i);
              pend_v       <= 1'b0;
`endif
            end else begin
              st     <= IDLE;
              busy_r <= 1'b0;
            end
          end else if (bus.tick) begin
            cnt <= cnt - DUR_W'(1);
          end
`ifdef ACT_QUEUE_EN
          if (!bus.abort && !pend_v && any_rise && !(run_end && COOL_TICKS == 0)) begin
            pend_v <= 1'b1;
            pend_i <= first_i;
          end
`endif
        end
        COOL: begin
          if (cool_end) begin
`ifdef ACT_QUEUE_EN
            if (chain_v) begin
              st           <= RUN;
              sel          <= chain_i;
              cnt          <= chain_dur;
              act_active_r <= onehot(chain_i);
              pend_v       <= 1'b0;
            end else begin
              st     <= IDLE;
              busy_r <= 1'b0;
            end
`else
            st     <= IDLE;
            busy_r <= 1'b0;
`endif
          end else if (bus.tick) begin
            ccnt <= ccnt - CCNT_W'(1);
          end
`ifdef ACT_QUEUE_EN
          if (!pend_v && any_rise && !cool_end) begin
            pend_v <= 1'b1;
            pend_i <= first_i;
          end
`endif
        end
        LEAVE: begin
          st     <= IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          st     <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.act_active = act_active_r;
  assign bus.act_done   = act_done_r;
  assign bus.leave_home = leave_home_r;
  assign bus.busy       = busy_r;
  assign bus.state      = st;

endmodule

// File: tb/tb_home_action_sched.sv
// tb_home_action_sched: directed and random key sequences against a tick-counting reference model.
module tb_home_action_sched;

  localparam int N_ACT      = 4;
  localparam int DUR_W      = 8;
  localparam int COOL_TICKS = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  home_action_sched_if #(.N_ACT(N_ACT), .DUR_W(DUR_W)) bus ();

  home_action_sched #(
    .N_ACT      (N_ACT),
    .DUR_W      (DUR_W),
    .COOL_TICKS (COOL_TICKS)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int vectors;
  int miscompares;

  logic [N_ACT*DUR_W-1:0] dur_vec;
  logic [3:0]             rnd_req;

  // Reference model: mode 0 idle, 1 running, 2 cooling, 3 leaving; time kept as ticks remaining.
  int         m_mode;
  int         m_cur;
  int         m_left;
  int         m_cool;
  logic [4:0] m_prev;
  logic [3:0] exp_active;
  logic [3:0] exp_done;
  logic       exp_leave;
  logic       exp_busy;
  logic [1:0] exp_state;

  function automatic void model_reset();
    m_mode     = 0;
    m_cur      = 0;
    m_left     = 0;
    m_cool     = 0;
    m_prev     = '1;
    exp_active = '0;
    exp_done   = '0;
    exp_leave  = 1'b0;
    exp_busy   = 1'b0;
    exp_state  = 2'd0;
  endfunction

  function automatic void model_step(input logic [3:0] req, input logic lv,
                                     input logic ab, input logic tk);
    logic [4:0] rises;
    rises  = {lv, req} & ~m_prev;
    m_prev = {lv, req};
    exp_done = '0;
    case (m_mode)
      0: begin
        if (rises[4]) begin
          m_mode = 3;
        end else if (rises[3:0] != 4'b0000) begin
          for (int i = 3; i >= 0; i--) if (rises[i]) m_cur = i;
          m_left = int'(dur_vec[m_cur*DUR_W +: DUR_W]);
          if (m_left == 0) m_left = 1;
          m_mode = 1;
        end
      end
      1: begin
        if (ab) begin
          m_mode = 0;
        end else if (tk) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            exp_done = 4'(1 << m_cur);
            m_cool   = COOL_TICKS;
            m_mode   = (COOL_TICKS > 0) ? 2 : 0;
          end
        end
      end
      2: begin
        if (tk) begin
          m_cool = m_cool - 1;
          if (m_cool == 0) m_mode = 0;
        end
      end
      default: m_mode = 0;
    endcase
    exp_active = (m_mode == 1) ? 4'(1 << m_cur) : 4'b0000;
    exp_leave  = (m_mode == 3);
    exp_busy   = (m_mode != 0);
    exp_state  = 2'(m_mode);
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_all();
    checkOutput("act_active", {4'b0, bus.act_active}, {4'b0, exp_active});
    checkOutput("act_done",   {4'b0, bus.act_done},   {4'b0, exp_done});
    checkOutput("leave_home", {7'b0, bus.leave_home}, {7'b0, exp_leave});
    checkOutput("busy",       {7'b0, bus.busy},       {7'b0, exp_busy});
    checkOutput("state",      {6'b0, bus.state},      {6'b0, exp_state});
  endtask

  // One clock: drive inputs, advance model on the edge, check just after it.
  task automatic applyStimulus(input logic [3:0] req, input logic lv,
                               input logic ab, input logic tk);
    bus.act_req   = req;
    bus.leave_req = lv;
    bus.abort     = ab;
    bus.tick      = tk;
    bus.act_dur   = dur_vec;
    @(posedge clk);
    model_step(req, lv, ab, tk);
    #1;
    check_all();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    dur_vec     = {8'd2, 8'd4, 8'd3, 8'd2};
    bus.act_req   = 4'b0010;
    bus.leave_req = 1'b1;
    bus.abort     = 1'b0;
    bus.tick      = 1'b0;
    bus.act_dur   = dur_vec;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] keys held through reset must not fire");
    for (int i = 0; i < 3; i++) applyStimulus(4'b0010, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] action 1, 3 ticks, cooldown 2 ticks, tick every 4 clk");
    for (int i = 0; i < 22; i++)
      applyStimulus((i < 3) ? 4'b0010 : 4'b0000, 1'b0, 1'b0, (i % 4) == 3);

    $display("[TB] simultaneous rises 1 and 3, both held");
    for (int i = 0; i < 24; i++) applyStimulus(4'b1010, 1'b0, 1'b0, (i % 2) == 1);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] leave and action 0 together");
    for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] abort on final tick");
    applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);

    $display("[TB] zero duration behaves as one tick");
    dur_vec[3*DUR_W +: DUR_W] = 8'd0;
    applyStimulus(4'b1000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 1'b0, 1'b0, (i % 2) == 0);

    $display("[TB] rise during cooldown is dropped");
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);

    $display("[TB] async reset mid-run with key held");
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
    #3;
    resetn = 1'b0;
    model_reset();
    #1;
    check_all();
    #2;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0);

    $display("[TB] random key traffic");
    rnd_req = 4'b0100;
    for (int i = 0; i < 400; i++) begin
      if ((i % 50) == 0) begin
        for (int k = 0; k < N_ACT; k++)
          dur_vec[k*DUR_W +: DUR_W] = 8'($urandom_range(0, 4));
      end
      for (int k = 0; k < N_ACT; k++)
        if ($urandom_range(0, 3) == 0) rnd_req[k] = ~rnd_req[k];
      applyStimulus(rnd_req, $urandom_range(0, 15) == 0,
                    $urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
